// File: rtl/ibex_pkg.sv
// Shared types for the ibex bus arbiter: the requester ID that is queued for each
// granted memory transaction.
package ibex_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_e;

  localparam arb_src_e ARB_SRC_INSTR = SRC_INSTR;
  localparam arb_src_e ARB_SRC_DATA  = SRC_DATA;

endpackage

// File: rtl/ibex_arb_src_fifo.sv
// In-order queue of requester IDs for granted but not yet answered memory transactions.
// A push while full or a pop while empty is ignored.
module ibex_arb_src_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  arb_src_e push_src,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output arb_src_e head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_src_e        slots [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) slots[i] <= ARB_SRC_INSTR;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_src;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// Shares one OBI memory port between instruction fetch and LSU, routing in-order responses
// back to their issuer. Define IBEX_BUS_ARB_RR_EN for round-robin instead of data > instr.
module ibex_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  arb_src_e sel;
  arb_src_e lock_src_q;
  arb_src_e head;
  logic     lock_q;
  logic     sel_req;
  logic     grant;
  logic     resp_pop;
  logic     fifo_full;
  logic     fifo_empty;

`ifdef IBEX_BUS_ARB_RR_EN
  arb_src_e rr_q;
`endif

  // A pending ungranted request keeps its owner so address/attributes stay stable.
  always_comb begin
    sel = ARB_SRC_INSTR;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (data_req_i && instr_req_i) begin
`ifdef IBEX_BUS_ARB_RR_EN
      sel = rr_q;
`else
      sel = ARB_SRC_DATA;
`endif
    end else if (data_req_i) begin
      sel = ARB_SRC_DATA;
    end
  end

  assign sel_req     = (sel == ARB_SRC_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o   = rst_ni && sel_req && !fifo_full;
  assign grant       = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = grant && (sel == ARB_SRC_INSTR);
  assign data_gnt_o  = grant && (sel == ARB_SRC_DATA);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == ARB_SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o   = 4'hF;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  // Responses with nothing outstanding are dropped rather than misrouted.
  assign resp_pop       = mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = resp_pop && (head == ARB_SRC_INSTR);
  assign data_rvalid_o  = resp_pop && (head == ARB_SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= ARB_SRC_INSTR;
    end else begin
      lock_q     <= mem_req_o && !mem_gnt_i;
      lock_src_q <= sel;
    end
  end

`ifdef IBEX_BUS_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= ARB_SRC_INSTR;
    end else if (grant) begin
      rr_q <= (sel == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
    end
  end
`endif

  ibex_arb_src_fifo #(
    .Depth(MaxOutstanding)
  ) u_src_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (grant),
    .push_src(sel),
    .pop     (resp_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_gnt_o && data_gnt_o));

  no_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Directed bench for ibex_bus_arbiter (default build, MaxOutstanding=2): reset, priority,
// lock, full gating, in-order response routing and simultaneous grant/response.
module tb_ibex_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h0000_2000;
  localparam logic [31:0] DW = 32'hCAFE_F00D;

  always #5 clk_i = ~clk_i;

  ibex_bus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives every input, then lets the combinational outputs settle before checks.
  task automatic applyStimulus(input logic ireq, input logic dreq, input logic dwe,
                               input logic [3:0] dbe, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic err);
    instr_req_i  = ireq;
    instr_addr_i = IA;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = DA;
    data_wdata_i = DW;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rvalid;
    mem_rdata_i  = rdata;
    mem_err_i    = err;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    #1;
    applyStimulus(1, 1, 1, 4'h3, 1, 1, 32'hDEAD_BEEF, 1);
    checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
    checkOutput("rst_data_gnt", 32'(data_gnt_o), 32'd0);
    checkOutput("rst_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
    checkOutput("rst_data_rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("rst_data_rdata", data_rdata_o, 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    tick();
    applyStimulus(0, 1, 0, 4'hF, 0, 1, 32'h1234_5678, 0);
    checkOutput("rst_mem_req_toggle", 32'(mem_req_o), 32'd0);
    checkOutput("rst_data_err", 32'(data_err_o), 32'd0);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 32'h0, 0);
    tick();
    rst_ni = 1'b1;
    #2;
    checkOutput("idle_mem_req", 32'(mem_req_o), 32'd0);
    tick();

    // Contention: data wins under fixed priority
    applyStimulus(1, 1, 1, 4'h3, 1, 0, 32'h0, 0);
    checkOutput("cont_data_gnt", 32'(data_gnt_o), 32'd1);
    checkOutput("cont_instr_gnt", 32'(instr_gnt_o), 32'd0);
    checkOutput("cont_mem_we", 32'(mem_we_o), 32'd1);
    checkOutput("cont_mem_addr", mem_addr_o, DA);
    checkOutput("cont_mem_be", 32'(mem_be_o), 32'h3);
    checkOutput("cont_mem_wdata", mem_wdata_o, DW);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 0, 1, 32'h5555_AAAA, 0);
    checkOutput("cont_data_rvalid", 32'(data_rvalid_o), 32'd1);
    checkOutput("cont_data_rdata", data_rdata_o, 32'h5555_AAAA);
    checkOutput("cont_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
    checkOutput("cont_instr_rdata", instr_rdata_o, 32'd0);
    tick();

    // Lock: instr waits for gnt while data arrives
    applyStimulus(1, 0, 0, 4'h0, 0, 0, 32'h0, 0);
    checkOutput("lock1_mem_req", 32'(mem_req_o), 32'd1);
    checkOutput("lock1_mem_addr", mem_addr_o, IA);
    checkOutput("lock1_instr_gnt", 32'(instr_gnt_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 4'hC, 0, 0, 32'h0, 0);
    checkOutput("lock2_mem_addr", mem_addr_o, IA);
    checkOutput("lock2_mem_be", 32'(mem_be_o), 32'hF);
    checkOutput("lock2_mem_wdata", mem_wdata_o, 32'd0);
    checkOutput("lock2_mem_we", 32'(mem_we_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 4'hC, 1, 0, 32'h0, 0);
    checkOutput("lock3_mem_addr", mem_addr_o, IA);
    checkOutput("lock3_instr_gnt", 32'(instr_gnt_o), 32'd1);
    checkOutput("lock3_data_gnt", 32'(data_gnt_o), 32'd0);
    tick();
    applyStimulus(0, 1, 1, 4'hC, 1, 0, 32'h0, 0);
    checkOutput("lock4_data_gnt", 32'(data_gnt_o), 32'd1);
    checkOutput("lock4_mem_addr", mem_addr_o, DA);
    tick();

    // Full: two outstanding, requests blocked
    applyStimulus(1, 1, 1, 4'hC, 1, 0, 32'h0, 0);
    checkOutput("full_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("full_instr_gnt", 32'(instr_gnt_o), 32'd0);
    checkOutput("full_data_gnt", 32'(data_gnt_o), 32'd0);
    tick();

    // Ordering: first response belongs to instr
    applyStimulus(1, 1, 1, 4'hC, 1, 1, 32'h1111_1111, 0);
    checkOutput("ord_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
    checkOutput("ord_instr_rdata", instr_rdata_o, 32'h1111_1111);
    checkOutput("ord_data_rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("ord_still_full", 32'(mem_req_o), 32'd0);
    tick();

    // Simultaneous grant and response at one outstanding
    applyStimulus(1, 1, 1, 4'hC, 1, 1, 32'h2222_2222, 1);
    checkOutput("sim_data_rvalid", 32'(data_rvalid_o), 32'd1);
    checkOutput("sim_data_rdata", data_rdata_o, 32'h2222_2222);
    checkOutput("sim_data_err", 32'(data_err_o), 32'd1);
    checkOutput("sim_instr_err", 32'(instr_err_o), 32'd0);
    checkOutput("sim_data_gnt", 32'(data_gnt_o), 32'd1);
    checkOutput("sim_instr_gnt", 32'(instr_gnt_o), 32'd0);
    tick();
    applyStimulus(1, 0, 0, 4'h0, 1, 0, 32'h0, 0);
    checkOutput("sim2_instr_gnt", 32'(instr_gnt_o), 32'd1);
    checkOutput("sim2_mem_be", 32'(mem_be_o), 32'hF);
    tick();
    applyStimulus(1, 1, 1, 4'hC, 1, 0, 32'h0, 0);
    checkOutput("sim3_full_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("sim3_data_gnt", 32'(data_gnt_o), 32'd0);
    tick();

    // Drain remaining data then instr responses
    applyStimulus(0, 0, 0, 4'h0, 0, 1, 32'h3333_3333, 0);
    checkOutput("drain1_data_rvalid", 32'(data_rvalid_o), 32'd1);
    checkOutput("drain1_data_rdata", data_rdata_o, 32'h3333_3333);
    checkOutput("drain1_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 0, 1, 32'h4444_4444, 1);
    checkOutput("drain2_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
    checkOutput("drain2_instr_rdata", instr_rdata_o, 32'h4444_4444);
    checkOutput("drain2_instr_err", 32'(instr_err_o), 32'd1);
    checkOutput("drain2_data_err", 32'(data_err_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 32'h0, 0);
    checkOutput("end_mem_req", 32'(mem_req_o), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
